alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the 32-bit combinational ALU.
- Decodes a 16-bit instruction, reads an 8x32 register file and registers A, B, S and carry_in for the ALU.
- Writes the ALU result R back into the register file when the issued op retires.
- Forwards the retiring result to a dependent instruction issued in the same cycle.
- Uses a valid/ready handshake on the instruction input and an out_valid/out_ready handshake on the issued op.

Parameters:
WIDTH, 32, datapath width (A, B, R, register entries)
IMM_W, 6, immediate field width, sign-extended to WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept instruction this cycle
instr  input  16  [15:13] op→S, [12:10] rd, [9:7] rs, [6] imm_sel, [5:3] rt, [5:0] imm, [2] cin, [1:0] ignored
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_s  output  3  registered ALU select
alu_cin  output  1  registered carry_in
alu_r  input  WIDTH  combinational result R from ALU
out_valid  output  1  issued op held in output register
out_ready  input  1  downstream accepts/retires op this cycle
out_rd  output  3  destination of held op
wb_en  output  1  combinational: register write occurring this cycle
wb_data  output  WIDTH  combinational: value written (alu_r)

Behaviour:
- Register file: 8 x WIDTH. r0 always reads 0; writes to r0 are discarded. All entries reset to 0.
- Reset (rst_n=0 at clk edge):
  - out_valid=0; alu_a=alu_b=0; alu_s=0; alu_cin=0; out_rd=0.
  - All RF entries cleared.
  - Reset mid-operation drops the held op without writeback.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Retire = out_valid && out_ready.
- Retire:
  - wb_en = retire && (out_rd != 0); wb_data = alu_r.
  - RF[out_rd] <= alu_r at the clock edge.
- Issue (on accept):
  - alu_a <= src(rs).
  - alu_b <= imm_sel ? sign_extend(instr[5:0]) : src(rt).
  - alu_s <= instr[15:13]; alu_cin <= instr[2]; out_rd <= instr[12:10]; out_valid <= 1.
  - Immediate bits [5:3] overlap rt; rt is ignored when imm_sel=1.
- src(x):
  - 0 if x==0.
  - Else alu_r if wb_en && out_rd==x (forwarding, same-cycle retire).
  - Else RF[x].
- No accept and retire: out_valid <= 0; alu_* and out_rd hold their last values.
- Neither accept nor retire: all outputs hold; alu_* stable while out_valid=1 and out_ready=0.
- Simultaneous retire and accept: writeback and new issue on the same edge. The new op sees the forwarded value.
- Latency: instruction accepted at edge N → operands on alu_* after edge N → result written to RF at the first edge where out_ready=1. Throughput 1 op/cycle with out_ready held high.
- alu_r is only sampled when wb_en=1; X on alu_r at other times must not propagate.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, alu_a=alu_b=0. After release, ADDI r1,r0,#5 (S=0, imm 000101) issues with alu_a=0, alu_b=5.
- Immediate sign extension: imm=6'b111111, rs=r0 → alu_b=0xFFFFFFFF, alu_a=0. imm=6'b011111 → alu_b=0x0000001F.
- Back-to-back forwarding, out_ready=1:
  - Drive ADDI r1,r0,#5 then ADD r2,r1,r1 on consecutive cycles.
  - Second op issues with alu_a=alu_b=5 (forwarded).
  - Next cycle wb_data=10 to r2.
- Backpressure: out_ready=0 for 3 cycles with a held op and in_valid=1 → in_ready=0; alu_a/alu_b/alu_s unchanged. Release → retire, writeback, and the pending instruction accepted on the same edge.
- r0 write: op with rd=0 retires with alu_r=0xDEADBEEF → wb_en=0. A later read of r0 yields alu_a=0.
- Reset mid-op: op held with out_valid=1, out_ready=0, then rst_n=0 → no RF write. After release, a read of that rd returns 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding a combinational 32-bit ALU: decodes, reads the
// 8-entry register file, holds the issued op and writes the ALU result back on retire.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_rd,
  output logic             wb_en,
  output logic [WIDTH-1:0] wb_data
);

  localparam int NREG = 8;

  // Handshake: an instruction transfers when in_valid && in_ready; the held op
  // retires when out_valid && out_ready. in_ready depends only on out_valid and
  // out_ready, never on in_valid, so there is no combinational loop upstream.

  logic [2:0]       dec_op;
  logic [2:0]       dec_rd;
  logic [2:0]       dec_rs;
  logic [2:0]       dec_rt;
  logic             dec_imm_sel;
  logic             dec_cin;
  logic [WIDTH-1:0] dec_imm;

  assign dec_op      = instr[15:13];
  assign dec_rd      = instr[12:10];
  assign dec_rs      = instr[9:7];
  assign dec_imm_sel = instr[6];
  assign dec_rt      = instr[5:3];
  assign dec_cin     = instr[2];
  assign dec_imm     = {{(WIDTH-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       s_q, s_d;
  logic             cin_q, cin_d;
  logic [2:0]       rd_q, rd_d;
  logic             valid_q, valid_d;

  logic             retire;
  logic             accept;
  logic             wb_en_c;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_t;

  always_comb begin
    retire   = valid_q && out_ready;
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;
    // A write is suppressed while reset is asserted, so nothing is reported either.
    wb_en_c  = retire && (rd_q != 3'd0) && rst_n;
  end

  // Source reads: r0 is hard zero; a same-cycle retire to the same register is
  // forwarded from alu_r. alu_r is only looked at when a write is happening.
  always_comb begin
    src_a = '0;
    if (dec_rs == 3'd0) begin
      src_a = '0;
    end else if (wb_en_c && (rd_q == dec_rs)) begin
      src_a = alu_r;
    end else begin
      src_a = rf_q[dec_rs];
    end
  end

  always_comb begin
    src_t = '0;
    if (dec_rt == 3'd0) begin
      src_t = '0;
    end else if (wb_en_c && (rd_q == dec_rt)) begin
      src_t = alu_r;
    end else begin
      src_t = rf_q[dec_rt];
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cin_d   = cin_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    if (accept) begin
      a_d     = src_a;
      b_d     = dec_imm_sel ? dec_imm : src_t;
      s_d     = dec_op;
      cin_d   = dec_cin;
      rd_d    = dec_rd;
      valid_d = 1'b1;
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_en_c) begin
      rf_d[rd_q] = alu_r;
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cin_q   <= 1'b0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cin_q   <= cin_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = s_q;
  assign alu_cin   = cin_q;
  assign out_rd    = rd_q;
  assign out_valid = valid_q;
  assign wb_en     = wb_en_c;
  assign wb_data   = wb_en_c ? alu_r : '0;

endmodule
